ifu_fetch: RTL and testbench

- Instruction-fetch front end. Owns the architectural PC register and fetches from instruction memory through a req/rsp handshake.
- Presents the fetched instruction to decode through a valid/ready handshake.
- Loads the next PC computed by the next-PC mux when the current instruction commits.
- Single outstanding fetch; sits between the next-PC logic, imem and decode in the single-issue NPC core.

---
 rtl/ifu_fetch_pkg.sv | 17 +
 rtl/ifu_fetch_if.sv | 48 ++++
 rtl/ifu_fetch.sv | 123 ++++++++++++
 tb/tb_ifu_fetch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch FSM states and
// architectural defaults.
package ifu_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        StReq,
        StWait,
        StOut,
        StExec,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: imem request/response channel and the decode-side
// instruction handshake. master = fetch unit, slave = imem + decode.
interface ifu_fetch_if #(
    parameter int unsigned XLEN = ifu_fetch_pkg::XLEN
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            imem_rsp_err;

    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err,
        output inst_valid,
        output inst,
        output inst_pc,
        output inst_fault,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  inst_fault,
        output inst_ready
    );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the PC, issues one outstanding imem fetch at a
// time and hands the result to decode, then waits for the commit that loads next_pc.
module ifu_fetch #(
    parameter int unsigned     XLEN     = ifu_fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = ifu_fetch_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc,
    input  logic            pc_update,
    ifu_fetch_if.master     bus,
    output logic [XLEN-1:0] pc,
    output logic            misalign_err,
    output logic [31:0]     fetch_cnt
);

    import ifu_fetch_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_fault_q, inst_fault_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;

    logic req_active;
    logic load_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
            misalign_q   <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
            misalign_q   <= misalign_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        misalign_d   = misalign_q;
        fetch_cnt_d  = fetch_cnt_q;
        req_active   = 1'b0;
        load_pc      = 1'b0;

        unique case (state_q)
            StReq: begin
                req_active = 1'b1;
                if (bus.imem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.imem_rsp_valid) begin
                    inst_d       = bus.imem_rsp_data;
                    inst_pc_d    = pc_q;
                    inst_fault_d = bus.imem_rsp_err;
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                    state_d      = StOut;
                end
            end
            StOut: begin
                if (bus.inst_ready) begin
                    // Commit in the same cycle as the handshake skips EXEC entirely.
                    if (pc_update) begin
                        load_pc = 1'b1;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                if (pc_update) begin
                    load_pc = 1'b1;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase

        if (load_pc) begin
            pc_d = next_pc;
            if (next_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = StHalt;
            end else begin
                state_d = StReq;
            end
        end
    end

    // Gated by rst so no request escapes while reset is held.
    assign bus.imem_req_valid = req_active & rst;
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = (state_q == StOut);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.inst_fault     = inst_fault_q;

    assign pc           = pc_q;
    assign misalign_err = misalign_q;
    assign fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed and randomized fetch transactions
// checked against a transaction-level model of PC, fetch count and halt state.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        pc_update;
    logic [31:0] pc;
    logic        misalign_err;
    logic [31:0] fetch_cnt;

    ifu_fetch_if bus ();

    ifu_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .next_pc      (next_pc),
        .pc_update    (pc_update),
        .bus          (bus),
        .pc           (pc),
        .misalign_err (misalign_err),
        .fetch_cnt    (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level model
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic        m_halt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
        pc_update          = 1'b0;
        next_pc            = '0;
    endtask

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_cnt  = '0;
        m_mis  = 1'b0;
        m_halt = 1'b0;
    endtask

    task automatic model_load(input logic [31:0] npc);
        m_pc = npc;
        if (npc % 4 != 0) begin
            m_mis  = 1'b1;
            m_halt = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // One complete instruction: request, response, decode handshake, commit.
    task automatic do_fetch(input int req_stall, input int rsp_lat, input logic [31:0] data,
                            input logic err, input int out_stall, input logic fast,
                            input logic [31:0] npc, input int exec_wait);
        logic [31:0] fpc;
        fpc = m_pc;
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < req_stall; i++) begin
            check("req_valid_stall", {31'd0, bus.imem_req_valid}, 32'd1);
            check("imem_addr_stall", bus.imem_addr, fpc);
            @(negedge clk);
        end
        bus.imem_req_ready = 1'b1;
        check("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("imem_addr", bus.imem_addr, fpc);
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        for (int i = 1; i < rsp_lat; i++) begin
            check("wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
            check("wait_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
            check("wait_pc", pc, m_pc);
            pc_update = 1'($urandom_range(0, 1));
            next_pc   = $urandom;
            @(negedge clk);
        end
        pc_update          = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        bus.imem_rsp_err   = err;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        bus.imem_rsp_err   = 1'($urandom_range(0, 1));
        m_cnt = m_cnt + 32'd1;
        for (int i = 0; i <= out_stall; i++) begin
            bus.inst_ready = (i == out_stall);
            if (i == out_stall) begin
                pc_update = fast;
                next_pc   = npc;
            end else begin
                pc_update = 1'($urandom_range(0, 1));
                next_pc   = $urandom;
            end
            check("inst_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("inst", bus.inst, data);
            check("inst_pc", bus.inst_pc, fpc);
            check("inst_fault", {31'd0, bus.inst_fault}, {31'd0, err});
            check("fetch_cnt", fetch_cnt, m_cnt);
            check("out_pc", pc, m_pc);
            @(negedge clk);
        end
        bus.inst_ready = 1'b0;
        pc_update      = 1'b0;
        if (!fast) begin
            for (int i = 0; i < exec_wait; i++) begin
                check("exec_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
                check("exec_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
                check("exec_pc", pc, m_pc);
                @(negedge clk);
            end
            pc_update = 1'b1;
            next_pc   = npc;
            @(negedge clk);
            pc_update = 1'b0;
        end
        model_load(npc);
        check("pc_after_load", pc, m_pc);
        check("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        check("req_valid_after_load", {31'd0, bus.imem_req_valid}, {31'd0, !m_halt});
        check("inst_valid_after_load", {31'd0, bus.inst_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap;

        // Reset state while rst is held low
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_inst_fault", {31'd0, bus.inst_fault}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check("rst_fetch_cnt", fetch_cnt, 32'd0);
        rst = 1'b1;
        #1;
        check("release_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);

        // First fetch, decode stalls 3 cycles then fast-path commit
        do_fetch(0, 1, 32'h0000_0413, 1'b0, 3, 1'b1, 32'h8000_0010, 0);
        // Request stall of 4, access fault response, commit through EXEC
        do_fetch(4, 3, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 32'h8000_0014, 2);

        for (int n = 0; n < 24; n++) begin
            logic [31:0] npc;
            npc = {16'h8000, 16'($urandom) & 16'hFFFC};
            do_fetch($urandom_range(0, 3), $urandom_range(1, 4), $urandom,
                     1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), npc, $urandom_range(0, 3));
        end

        // Misaligned commit halts the fetcher
        do_fetch(0, 1, $urandom, 1'b0, 0, 1'b0, 32'h8000_0006, 1);
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.imem_rsp_valid = 1'($urandom_range(0, 1));
            bus.inst_ready     = 1'b1;
            pc_update          = 1'b1;
            next_pc            = 32'h8000_0100;
            @(negedge clk);
            check("halt_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
            check("halt_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
            check("halt_pc", pc, 32'h8000_0006);
            check("halt_misalign", {31'd0, misalign_err}, 32'd1);
        end
        idle_inputs();

        // Reset asserted mid-WAIT; stale response afterwards is dropped
        apply_reset();
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midwait_rst_pc", pc, RESET_PC);
        check("midwait_rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        check("midwait_rst_misalign", {31'd0, misalign_err}, 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        check("stale_rsp_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("stale_rsp_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("stale_rsp_fetch_cnt", fetch_cnt, 32'd0);
        do_fetch(0, 2, 32'h0000_0013, 1'b0, 1, 1'b1, 32'h8000_0020, 0);

        // Fetch counter wrap: preload all-ones, check the increment that follows
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        #1;
        check("cnt_preload", fetch_cnt, 32'hFFFF_FFFF);
        bus.imem_rsp_valid = 1'b1;
        #1;
        wrap = 32'hFFFF_FFFF;
        wrap = wrap + 32'd1;
        check("cnt_wrap", dut.fetch_cnt_d, wrap);
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        #1;
        release dut.fetch_cnt_q;
        repeat (2) @(negedge clk);
        check("cnt_after_reset", fetch_cnt, 32'd0);
        rst = 1'b1;
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
